// File: rtl/cci_mem_rsp_pkg.sv
// cci_mem_rsp_pkg
//   Shared types and constants for the CCI memory responder.
//   - t_line_idx  : index into the line store (low address bits)
//   - t_cnt       : free-running cycle counter / due-time type
//   - t_rd_entry  : pending-read queue entry {data, mdata, due}
//   - t_ack_entry : pending write-ack entry {mdata, due} (jitter build only)
//   - LFSR_SEED / LFSR_TAPS : 8-bit Fibonacci LFSR, taps 8,6,5,4
//   The responder's DATA_BITS / MDATA_BITS / MEM_LINES_LOG2 defaults are
//   taken from the widths below and must stay in step with them.
package cci_mem_rsp_pkg;

  localparam int DATA_W     = 512;
  localparam int MDATA_W    = 16;
  localparam int LINE_IDX_W = 6;
  localparam int CNT_W      = 8;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Bits 7,5,4,3 correspond to polynomial taps 8,6,5,4.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef logic [LINE_IDX_W-1:0] t_line_idx;
  typedef logic [CNT_W-1:0]      t_cnt;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [MDATA_W-1:0] mdata;
    t_cnt               due;
  } t_rd_entry;

  typedef struct packed {
    logic [MDATA_W-1:0] mdata;
    t_cnt               due;
  } t_ack_entry;

  function automatic logic [7:0] lfsr_next(input logic [7:0] state);
    return {state[6:0], ^(state & LFSR_TAPS)};
  endfunction

  // Later of two due times, compared modulo the counter width. Valid as
  // long as the two values are less than half the counter range apart.
  function automatic t_cnt due_max(input t_cnt cand, input t_cnt floor_due);
    t_cnt diff;
    diff = cand - floor_due;
    return diff[CNT_W-1] ? floor_due : cand;
  endfunction

endpackage

// File: rtl/cci_mem_rsp_fifo.sv
// cci_mem_rsp_fifo
//   Synchronous FIFO with head peek. DEPTH must be a power of two.
//   A push while full is accepted when a pop happens in the same cycle.
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     push, push_data   : write request and payload
//     pop               : remove head entry (ignored when empty)
//     head              : current head entry (valid when !empty)
//     full, empty       : status flags
//     occupancy         : number of stored entries (0..DEPTH)
module cci_mem_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign occupancy = count;
  assign head      = mem[rd_ptr];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cci_mem_responder.sv
// cci_mem_responder
//   Host-memory stand-in for CCI-style AFUs. Reads (channel 0) and writes
//   (channel 1) are serviced from an internal line store indexed by the
//   low MEM_LINES_LOG2 address bits; upper address bits are ignored.
//   Reads answer after RD_LATENCY cycles, in order; writes ack one cycle
//   after the request. A read hitting a full queue is dropped and sets
//   the sticky overflow_err.
//   Optional build macro CCI_MEM_RSP_JITTER_EN adds 0-3 cycles of
//   LFSR-driven extra latency to reads and write acks, keeping order.
//   Ports:
//     clk, reset                      : clock, synchronous active-high reset
//     c0_req_valid/addr/mdata         : read request
//     c0_almost_full                  : registered queue backpressure hint
//     c0_rsp_valid/data/mdata         : read response pulse
//     c1_req_valid/addr/data/mdata    : write request
//     c1_almost_full                  : constant 0
//     c1_rsp_valid/mdata              : write ack pulse
//     overflow_err                    : sticky dropped-read flag
module cci_mem_responder
  import cci_mem_rsp_pkg::*;
#(
  parameter int ADDR_BITS      = 42,
  parameter int MEM_LINES_LOG2 = LINE_IDX_W,
  parameter int DATA_BITS      = DATA_W,
  parameter int MDATA_BITS     = MDATA_W,
  parameter int RD_LATENCY     = 4,
  parameter int QUEUE_DEPTH    = 8,
  parameter int AF_THRESH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c0_req_valid,
  input  logic [ADDR_BITS-1:0]  c0_req_addr,
  input  logic [MDATA_BITS-1:0] c0_req_mdata,
  output logic                  c0_almost_full,
  output logic                  c0_rsp_valid,
  output logic [DATA_BITS-1:0]  c0_rsp_data,
  output logic [MDATA_BITS-1:0] c0_rsp_mdata,
  input  logic                  c1_req_valid,
  input  logic [ADDR_BITS-1:0]  c1_req_addr,
  input  logic [DATA_BITS-1:0]  c1_req_data,
  input  logic [MDATA_BITS-1:0] c1_req_mdata,
  output logic                  c1_almost_full,
  output logic                  c1_rsp_valid,
  output logic [MDATA_BITS-1:0] c1_rsp_mdata,
  output logic                  overflow_err
);

  localparam int   LINES    = 1 << MEM_LINES_LOG2;
  localparam int   OCC_W    = $clog2(QUEUE_DEPTH) + 1;
  localparam t_cnt RD_LAT_C = t_cnt'(RD_LATENCY);

  logic [DATA_BITS-1:0] store [LINES];
  t_line_idx            rd_idx;
  t_line_idx            wr_idx;
  logic [DATA_BITS-1:0] rd_line;
  t_cnt                 cnt;
  t_cnt                 rd_due;
  t_rd_entry            rd_push_entry;
  t_rd_entry            rd_head;
  logic                 rd_full;
  logic                 rd_empty;
  logic                 rd_pop;
  logic                 rd_accept;
  logic [OCC_W-1:0]     rd_occ;
  logic                 unused_addr_bits;

  assign rd_idx = c0_req_addr[MEM_LINES_LOG2-1:0];
  assign wr_idx = c1_req_addr[MEM_LINES_LOG2-1:0];
  assign unused_addr_bits = ^{c0_req_addr[ADDR_BITS-1:MEM_LINES_LOG2],
                              c1_req_addr[ADDR_BITS-1:MEM_LINES_LOG2]};

  assign c1_almost_full = 1'b0;

  // Line store: written in the request cycle, never reset.
  always_ff @(posedge clk) begin
    if (c1_req_valid) store[wr_idx] <= c1_req_data;
  end

  // Same-cycle write to the read line wins, so the read sees new data.
  assign rd_line = (c1_req_valid && (wr_idx == rd_idx)) ? c1_req_data : store[rd_idx];

  // Free-running time base; due times are compared against it modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt + 1'b1;
  end

  assign rd_pop        = !rd_empty && (rd_head.due == cnt);
  assign rd_accept     = c0_req_valid && (!rd_full || rd_pop);
  assign rd_push_entry = '{data: rd_line, mdata: c0_req_mdata, due: rd_due};

  cci_mem_rsp_fifo #(
    .WIDTH($bits(t_rd_entry)),
    .DEPTH(QUEUE_DEPTH)
  ) u_rd_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_accept),
    .push_data (rd_push_entry),
    .pop       (rd_pop),
    .head      (rd_head),
    .full      (rd_full),
    .empty     (rd_empty),
    .occupancy (rd_occ)
  );

  // The response is driven straight from the queue head in its due cycle,
  // which keeps the latency exact even for RD_LATENCY = 1. Gating with
  // reset keeps the reset cycle itself silent.
  assign c0_rsp_valid = rd_pop && !reset;
  assign c0_rsp_data  = c0_rsp_valid ? rd_head.data  : '0;
  assign c0_rsp_mdata = c0_rsp_valid ? rd_head.mdata : '0;

  always_ff @(posedge clk) begin
    if (reset)                          overflow_err <= 1'b0;
    else if (c0_req_valid && !rd_accept) overflow_err <= 1'b1;
  end

  // Hint derived from the registered occupancy, so it trails by one cycle.
  always_ff @(posedge clk) begin
    if (reset) c0_almost_full <= 1'b0;
    else       c0_almost_full <= (QUEUE_DEPTH - int'(rd_occ)) <= AF_THRESH;
  end

`ifdef CCI_MEM_RSP_JITTER_EN
  logic [7:0] lfsr;
  t_cnt       rd_cand;
  t_cnt       last_rd_due;
  logic       rd_has_older;
  t_ack_entry ack_push_entry;
  t_ack_entry ack_head;
  t_cnt       ack_cand;
  t_cnt       ack_due;
  t_cnt       last_ack_due;
  logic       ack_empty;
  logic       ack_pop;
  logic       ack_has_older;
  logic [2:0] ack_occ;
  logic       ack_full_unused;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  // A new due time is only pushed past the previous one when an older
  // entry will still be waiting; an empty queue imposes no ordering floor.
  assign rd_has_older = !rd_empty && !(rd_pop && (rd_occ == OCC_W'(1)));
  assign rd_cand      = cnt + RD_LAT_C + t_cnt'(lfsr[1:0]);
  assign rd_due       = rd_has_older ? due_max(rd_cand, last_rd_due + t_cnt'(1)) : rd_cand;

  always_ff @(posedge clk) begin
    if (reset)          last_rd_due <= '0;
    else if (rd_accept) last_rd_due <= rd_due;
  end

  // Ack dues are strictly increasing and at most 4 cycles ahead, so four
  // entries always suffice and writes never need to stall.
  assign ack_pop        = !ack_empty && (ack_head.due == cnt);
  assign ack_has_older  = !ack_empty && !(ack_pop && (ack_occ == 3'd1));
  assign ack_cand       = cnt + t_cnt'(1) + t_cnt'(lfsr[1:0]);
  assign ack_due        = ack_has_older ? due_max(ack_cand, last_ack_due + t_cnt'(1)) : ack_cand;
  assign ack_push_entry = '{mdata: c1_req_mdata, due: ack_due};

  always_ff @(posedge clk) begin
    if (reset)             last_ack_due <= '0;
    else if (c1_req_valid) last_ack_due <= ack_due;
  end

  cci_mem_rsp_fifo #(
    .WIDTH($bits(t_ack_entry)),
    .DEPTH(4)
  ) u_ack_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (c1_req_valid),
    .push_data (ack_push_entry),
    .pop       (ack_pop),
    .head      (ack_head),
    .full      (ack_full_unused),
    .empty     (ack_empty),
    .occupancy (ack_occ)
  );

  assign c1_rsp_valid = ack_pop && !reset;
  assign c1_rsp_mdata = c1_rsp_valid ? ack_head.mdata : '0;
`else
  assign rd_due = cnt + RD_LAT_C;

  // Fixed one-cycle write ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      c1_rsp_valid <= 1'b0;
      c1_rsp_mdata <= '0;
    end else begin
      c1_rsp_valid <= c1_req_valid;
      c1_rsp_mdata <= c1_req_valid ? c1_req_mdata : '0;
    end
  end
`endif

endmodule

// File: doc/cci_mem_responder.md
Name: cci_mem_responder

Overview:
- Host-memory responder for the CCI-style request/response interface used by our AFUs; it is the other end of what an AFU initiates.
- Accepts single-line read requests (channel 0) and write requests (channel 1) from an AFU and services them from an internal line-addressed store.
- Returns read data and write acks with fixed, in-order latency, so AFU state machines can be tested on the FPGA or in simulation without the FIU/host.

Parameters:
ADDR_BITS, 42, cache-line address width
MEM_LINES_LOG2, 6, log2 of store depth in lines (64 lines)
DATA_BITS, 512, line width
MDATA_BITS, 16, request tag width, echoed in responses
RD_LATENCY, 4, cycles from read accept to read response (>=1)
QUEUE_DEPTH, 8, pending-read queue entries (power of 2, >= RD_LATENCY)
AF_THRESH, 2, free-entry count at or below which almost_full asserts

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
c0_req_valid  in  1  read request
c0_req_addr  in  ADDR_BITS  line address
c0_req_mdata  in  MDATA_BITS  read tag
c0_almost_full  out  1  read backpressure hint
c0_rsp_valid  out  1  read response, one-cycle pulse
c0_rsp_data  out  DATA_BITS  read data
c0_rsp_mdata  out  MDATA_BITS  echoed tag
c1_req_valid  in  1  write request
c1_req_addr  in  ADDR_BITS  line address
c1_req_data  in  DATA_BITS  write data
c1_req_mdata  in  MDATA_BITS  write tag
c1_almost_full  out  1  always 0 (writes never stall)
c1_rsp_valid  out  1  write ack, one-cycle pulse
c1_rsp_mdata  out  MDATA_BITS  echoed tag
overflow_err  out  1  sticky: a read arrived while the queue was full

Behaviour:
- Reset: all outputs 0, queue emptied, cycle counter 0, overflow_err cleared. Store contents are not reset.
- Reset mid-operation: queued reads are discarded and never answered; no response appears in the cycle after reset.
- Store indexing: line index = addr[MEM_LINES_LOG2-1:0]. Upper address bits are ignored, so addresses wrap.
- Write path:
  - On c1_req_valid the line is written in the same cycle.
  - c1_rsp_valid pulses exactly 1 cycle later with that request's mdata.
  - Back-to-back writes give back-to-back acks.
- Read path:
  - On c0_req_valid with the queue not full, the line is read in the accept cycle and pushed with mdata and due = cnt + RD_LATENCY.
  - cnt is a free-running counter of at least 8 bits, compared modulo its width.
  - When the head entry's due equals cnt, the entry is popped and c0_rsp_valid pulses with its data and mdata.
  - Latency is exactly RD_LATENCY cycles, responses are in order, and at most one response is issued per cycle.
- Same-cycle read and write to the same line: write-before-read. The read returns the new data.
- Queue full and a read arrives: the request is dropped, no response is issued, and overflow_err is set until reset.
- Push and pop in the same cycle while full: the push is accepted.
- c0_almost_full = (QUEUE_DEPTH - occupancy) <= AF_THRESH, registered, so it lags by 1 cycle.
- No backpressure on the response channels; the AFU must always accept.

Optional Feature:
- CCI_MEM_RSP_JITTER_EN defined:
  - Each accepted read gets an extra 0-3 cycles from an 8-bit LFSR (taps 8,6,5,4, seed 8'hA5 at reset).
  - due = max(cnt + RD_LATENCY + extra, previous due + 1), so order is preserved.
  - Write ack delay = 1 + LFSR[1:0], with acks kept in order through a 4-entry ack FIFO.
- Undefined: fixed latencies exactly as above.

Decomposition:
- Package cci_mem_rsp_pkg: t_rd_entry {data, mdata, due}, t_line_idx, and the constants LFSR_SEED and LFSR_TAPS.
- Sub-module cci_mem_rsp_fifo: parameterised synchronous FIFO providing full, empty, occupancy and head peek. It is used for the read queue and, when jitter is enabled, for the ack FIFO.

Test Plan:
- Write addr 0x3, data 0xDEAD_BEEF, mdata 0x11 -> c1_rsp_valid at +1 with mdata 0x11. Then read addr 0x3, mdata 0x22 -> c0_rsp_valid at +4 with data 0xDEAD_BEEF and mdata 0x22.
- Same cycle: write addr 0x5 with 0x1234 and read addr 0x5 -> read returns 0x1234.
- Read addr 0x43 after writing 0x77 to addr 0x3 -> returns 0x77 (index wrap).
- 9 reads on consecutive cycles, mdata 0-8 (RD_LATENCY=16) -> c0_almost_full asserts after the 6th accept; the 9th is dropped and overflow_err=1; responses carry mdata 0-7 only, in order.
- Reset asserted 2 cycles after 3 reads are accepted -> no c0_rsp_valid ever issued; a later read of a previously written line returns the stored data.
- Jitter enabled, 20 back-to-back reads -> mdata strictly increasing; every latency is in 4-7 cycles or is forced later by the previous response.
